oam_dma: RTL

Sprite-attribute DMA engine for the Game Boy core. It sits between the core's CPU bus and the external memory bus that serves cartridge ROM and WRAM. A CPU write to register 0xFF46 makes it take over that bus and copy 160 bytes from `{page, 8'h00}` into OAM, one byte per machine cycle. While the copy runs it reports busy so the core can block CPU accesses outside HRAM.

---
 rtl/gb_pkg.sv | 22 ++
 rtl/oam_dma.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy core definitions used by the OAM DMA engine.
package gb_pkg;

    // CPU-visible DMA source-page register and OAM window base.
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;

    // Pages at or above this value are echo RAM and alias onto WRAM (page - 0x20).
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // Fold an echo-RAM source page back onto the WRAM page it mirrors.
    function automatic logic [7:0] echo_map(input logic [7:0] page);
        return (page >= ECHO_BASE) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to 0xFF46 takes over the memory bus and copies
// LENGTH bytes from {page, 8'h00} into OAM, one byte per machine cycle.
//
// Handshake: there is no valid/ready pair here. reg_wr is a one-clock
// command strobe that is always accepted and always wins over m_tick in
// the same clock; m_tick is a one-clock enable that paces every transfer
// step; oam_we is a one-clock write pulse with no back-pressure.
module oam_dma
    import gb_pkg::*;
#(
    parameter int LENGTH      = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m_tick,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        bus_own,
    output logic [15:0] dma_A,
    output logic        dma_rd_n,
    output logic        dma_cs_n,
    input  logic [7:0]  Di,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output dma_state_t  dbg_state,
    output logic [7:0]  dbg_idx
);

    localparam logic [7:0] IDX_LAST = 8'(LENGTH - 1);
    localparam logic [7:0] DLY_LAST = (START_DELAY > 0) ? 8'(START_DELAY - 1) : 8'd0;

    dma_state_t  r_state;
    dma_state_t  w_next_state;
    logic [7:0]  r_src_hi;
    logic [7:0]  r_idx;
    logic [7:0]  r_dly;
    logic [7:0]  r_reg;
    logic [15:0] r_dma_a;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_wdata;
    logic        r_oam_we;
    logic        w_xfer_tick;
    logic        w_last;

    // A byte is taken only on a tick in XFER that is not overridden by a write.
    assign w_xfer_tick = (r_state == XFER) && m_tick && !reg_wr;
    assign w_last      = (r_idx == IDX_LAST);

    // Next-state logic: a register write restarts from any state.
    always_comb begin
        w_next_state = r_state;
        if (reg_wr) begin
            w_next_state = (START_DELAY == 0) ? XFER : START;
        end else begin
            case (r_state)
                START:   if (m_tick && (r_dly == DLY_LAST)) w_next_state = XFER;
                XFER:    if (m_tick && w_last)              w_next_state = IDLE;
                default: w_next_state = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: register capture, delay/index counters and the OAM write pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_reg       <= 8'hFF;
            r_src_hi    <= 8'h00;
            r_idx       <= 8'h00;
            r_dly       <= 8'h00;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
            r_oam_we    <= 1'b0;
        end else begin
            r_oam_we <= 1'b0;
            if (reg_wr) begin
                r_reg    <= reg_wdata;
                r_src_hi <= echo_map(reg_wdata);
                r_idx    <= 8'h00;
                r_dly    <= 8'h00;
            end else begin
                if ((r_state == START) && m_tick) begin
                    r_dly <= r_dly + 8'd1;
                end
                if (w_xfer_tick) begin
                    r_oam_wdata <= Di;
                    r_oam_addr  <= r_idx;
                    r_oam_we    <= 1'b1;
                    // Hold at the last index so idx never leaves the page.
                    if (!w_last) begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
            end
        end
    end

    // Remember the last driven source address so dma_A holds it outside XFER.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dma_a <= 16'h0000;
        end else if (r_state == XFER) begin
            r_dma_a <= {r_src_hi, r_idx};
        end
    end

    assign reg_rdata = r_reg;
    assign bus_own   = (r_state != IDLE);
    // Busy also covers the clock carrying the final OAM write.
    assign busy      = (r_state != IDLE) || r_oam_we;
    assign dma_A     = (r_state == XFER) ? {r_src_hi, r_idx} : r_dma_a;
    assign dma_rd_n  = (r_state != XFER);
    assign dma_cs_n  = (r_state != XFER);
    assign oam_addr  = r_oam_addr;
    assign oam_wdata = r_oam_wdata;
    assign oam_we    = r_oam_we;
    assign dbg_state = r_state;
    assign dbg_idx   = r_idx;

endmodule
